// File: rtl/sst_engine.sv
// sst_engine: save-state bus initiator streaming mapper registers to/from the host; optional SST_IDX_CHECK_EN verifies the mapper index byte on load
module sst_engine #(
    parameter int REG_CNT  = 128,
    parameter int IDX_ADDR = 127
) (
    input  logic       m2,
    input  logic       map_rst,
    input  logic       save_req,
    input  logic       load_req,
    input  logic       abort,
    input  logic [7:0] map_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    output logic       rx_rdy,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we_reg,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di
);
    typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_TX, LOAD_RX, LOAD_WR, DONE} state_t;
    localparam logic [7:0] LAST = 8'(REG_CNT - 1);
    localparam logic [7:0] IDX  = 8'(IDX_ADDR);
    state_t     state_q, state_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       tx_vld_q, tx_vld_d, rx_rdy_q, rx_rdy_d;
    logic       sst_act_q, sst_act_d, sst_we_reg_q, sst_we_reg_d;
    logic [7:0] tx_data_q, tx_data_d, sst_addr_q, sst_addr_d, sst_dato_q, sst_dato_d;
    logic       last, idx_bad;
    logic [7:0] addr_nxt;
    assign last     = sst_addr_q == LAST;
    assign addr_nxt = last ? sst_addr_q : sst_addr_q + 8'd1;
`ifdef SST_IDX_CHECK_EN
    assign idx_bad = (sst_addr_q == IDX) && (rx_data != map_idx);
`else
    logic unused_idx;
    assign idx_bad    = 1'b0;
    assign unused_idx = ^{map_idx, IDX};
`endif
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        tx_data_d    = tx_data_q;
        tx_vld_d     = tx_vld_q;
        rx_rdy_d     = rx_rdy_q;
        sst_act_d    = sst_act_q;
        sst_addr_d   = sst_addr_q;
        sst_dato_d   = sst_dato_q;
        sst_we_reg_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: if (save_req || load_req) begin
                state_d    = save_req ? SAVE_RD : LOAD_RX;
                rx_rdy_d   = !save_req;
                sst_act_d  = 1'b1;
                sst_addr_d = 8'd0;
                err_d      = 1'b0;
            end
            SAVE_RD: begin
                tx_data_d = sst_di;
                tx_vld_d  = 1'b1;
                state_d   = SAVE_TX;
            end
            SAVE_TX: if (tx_rdy) begin
                tx_vld_d   = 1'b0;
                sst_addr_d = addr_nxt;
                state_d    = last ? DONE : SAVE_RD;
            end
            LOAD_RX: if (rx_vld) begin
                rx_rdy_d     = 1'b0;
                err_d        = err_q | idx_bad;
                sst_we_reg_d = !idx_bad;
                sst_dato_d   = idx_bad ? sst_dato_q : rx_data;
                state_d      = idx_bad ? DONE : LOAD_WR;
            end
            LOAD_WR: begin
                rx_rdy_d   = !last;
                sst_addr_d = addr_nxt;
                state_d    = last ? DONE : LOAD_RX;
            end
            DONE: begin
                done_d     = 1'b1;
                sst_act_d  = 1'b0;
                sst_addr_d = 8'd0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort drops any in-flight byte; DONE still produces the done pulse
        if (abort && state_q != IDLE && state_q != DONE) begin
            state_d      = DONE;
            err_d        = 1'b1;
            tx_vld_d     = 1'b0;
            rx_rdy_d     = 1'b0;
            sst_we_reg_d = 1'b0;
        end
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end
    always_ff @(negedge m2) begin
        if (map_rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_vld_q     <= 1'b0;
            rx_rdy_q     <= 1'b0;
            sst_act_q    <= 1'b0;
            sst_addr_q   <= 8'd0;
            sst_we_reg_q <= 1'b0;
            sst_dato_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
            rx_rdy_q     <= rx_rdy_d;
            sst_act_q    <= sst_act_d;
            sst_addr_q   <= sst_addr_d;
            sst_we_reg_q <= sst_we_reg_d;
            sst_dato_q   <= sst_dato_d;
        end
    end
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign tx_data    = tx_data_q;
    assign tx_vld     = tx_vld_q;
    assign rx_rdy     = rx_rdy_q;
    assign sst_act    = sst_act_q;
    assign sst_addr   = sst_addr_q;
    assign sst_we_reg = sst_we_reg_q;
    assign sst_dato   = sst_dato_q;
endmodule

// File: tb/tb_sst_engine.sv
// tb_sst_engine: scoreboard bench for sst_engine save/load/abort/reset behaviour
module tb_sst_engine;
    logic       m2 = 1'b0, map_rst = 1'b0, save_req = 1'b0, load_req = 1'b0, abort = 1'b0;
    logic [7:0] map_idx = 8'h53;
    logic       busy, done, err, tx_vld, rx_rdy, sst_act, sst_we_reg;
    logic [7:0] tx_data, sst_addr, sst_dato, sst_di, rx_data;
    logic       tx_rdy = 1'b0, rx_vld = 1'b0, host_clr = 1'b0;
    logic [7:0] last_byte = 8'd127;
    int         host_idx = 0, cyc = 0, c0 = 0, done_cnt = 0, done_cyc = 0;
    int         checks = 0, failures = 0;
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  et;
    logic [15:0] ew;
`ifdef SST_IDX_CHECK_EN
    localparam bit IDX_CHK = 1'b1;
`else
    localparam bit IDX_CHK = 1'b0;
`endif

    sst_engine dut (
        .m2(m2), .map_rst(map_rst), .save_req(save_req), .load_req(load_req), .abort(abort),
        .map_idx(map_idx), .busy(busy), .done(done), .err(err), .tx_data(tx_data), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy), .sst_act(sst_act),
        .sst_addr(sst_addr), .sst_we_reg(sst_we_reg), .sst_dato(sst_dato), .sst_di(sst_di)
    );

    always #5 m2 = ~m2;
    assign sst_di  = (sst_addr == 8'd127) ? map_idx : (sst_addr ^ 8'h5A);
    assign rx_data = (host_idx == 127) ? last_byte : 8'(host_idx);

    always @(negedge m2) begin
        cyc <= cyc + 1;
        if (host_clr) host_idx <= 0;
        else if (rx_vld && rx_rdy) host_idx <= host_idx + 1;
    end

    // monitor samples after the bench drives inputs and before the next falling edge
    always @(posedge m2) begin
        #3;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_vld === 1'b1 && tx_rdy) begin
            checks++;
            if (exp_tx.size() == 0) begin
                failures++;
                $display("FAIL tx_extra got=%02h expected=none", tx_data);
            end else begin
                et = exp_tx.pop_front();
                if (tx_data !== et) begin
                    failures++;
                    $display("FAIL tx_byte got=%02h expected=%02h", tx_data, et);
                end
            end
        end
        if (sst_we_reg === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL wr_extra got addr=%02h dato=%02h expected=none", sst_addr, sst_dato);
            end else begin
                ew = exp_wr.pop_front();
                if ({sst_addr, sst_dato} !== ew || sst_act !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_strobe got addr=%02h dato=%02h act=%b expected addr=%02h dato=%02h act=1",
                             sst_addr, sst_dato, sst_act, ew[15:8], ew[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge m2);
        #2;
    endtask

    task automatic start(input bit s, input bit l);
        tick();
        save_req = s;
        load_req = l;
        c0 = cyc;
        tick();
        save_req = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        for (int i = 0; i < lim && done_cnt == d0; i++) tick();
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL done_timeout got=none expected=done within %0d cycles", lim);
        end
        repeat (2) tick();
    endtask

    task automatic push_save();
        exp_tx.delete();
        for (int i = 0; i < 128; i++) exp_tx.push_back(i == 127 ? 8'h53 : 8'(i) ^ 8'h5A);
    endtask

    task automatic test_reset();
        map_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, err, tx_vld, tx_data, rx_rdy, sst_act, sst_addr, sst_we_reg, sst_dato} !== 36'd0) begin
            failures++;
            $display("FAIL reset_values got=%h expected=0",
                     {busy, done, err, tx_vld, tx_data, rx_rdy, sst_act, sst_addr, sst_we_reg, sst_dato});
        end
        map_rst = 1'b0;
        tick();
    endtask

    task automatic test_save();
        int d0;
        map_idx = 8'h53;
        tx_rdy = 1'b1;
        push_save();
        d0 = done_cnt;
        start(1'b1, 1'b0);
        checks++;
        if (sst_act !== 1'b1 || sst_addr !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL save_start got act=%b addr=%02h busy=%b expected act=1 addr=00 busy=1", sst_act, sst_addr, busy);
        end
        wait_done(d0, 400);
        checks++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 258) begin
            failures++;
            $display("FAIL save_done got count=%0d delay=%0d expected count=1 delay=258", done_cnt - d0, done_cyc - c0);
        end
        checks++;
        if (err !== 1'b0 || exp_tx.size() != 0 || sst_act !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL save_end got err=%b left=%0d act=%b busy=%b expected err=0 left=0 act=0 busy=0",
                     err, exp_tx.size(), sst_act, busy);
        end
    endtask

    task automatic test_load(input bit bad);
        int d0;
        bit exp_err;
        map_idx   = bad ? 8'h53 : 8'h7F;
        last_byte = bad ? 8'h00 : 8'd127;
        exp_err   = bad && IDX_CHK;
        exp_wr.delete();
        for (int i = 0; i < 127; i++) exp_wr.push_back({8'(i), 8'(i)});
        if (!exp_err) exp_wr.push_back({8'd127, last_byte});
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
        rx_vld = 1'b1;
        d0 = done_cnt;
        start(1'b0, 1'b1);
        wait_done(d0, 400);
        rx_vld = 1'b0;
        checks++;
        if (done_cnt - d0 != 1 || (!exp_err && done_cyc - c0 != 258)) begin
            failures++;
            $display("FAIL load_done got count=%0d delay=%0d expected count=1 delay=258", done_cnt - d0, done_cyc - c0);
        end
        checks++;
        if (err !== exp_err || exp_wr.size() != 0 || sst_act !== 1'b0) begin
            failures++;
            $display("FAIL load_end bad=%b got err=%b left=%0d act=%b expected err=%b left=0 act=0",
                     bad, err, exp_wr.size(), sst_act, exp_err);
        end
        exp_wr.delete();
    endtask

    task automatic test_stall();
        int d0;
        bit stalled = 1'b0;
        tx_rdy = 1'b1;
        push_save();
        d0 = done_cnt;
        start(1'b1, 1'b0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            tick();
            if (!stalled && tx_vld === 1'b1 && tx_data === 8'h59) begin
                tx_rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    checks++;
                    if (tx_vld !== 1'b1 || tx_data !== 8'h59) begin
                        failures++;
                        $display("FAIL stall_hold cycle=%0d got vld=%b data=%02h expected vld=1 data=59", k, tx_vld, tx_data);
                    end
                end
                tx_rdy = 1'b1;
                stalled = 1'b1;
            end
        end
        repeat (2) tick();
        checks++;
        if (!stalled || done_cnt - d0 != 1 || exp_tx.size() != 0) begin
            failures++;
            $display("FAIL stall_end got stalled=%b count=%0d left=%0d expected stalled=1 count=1 left=0",
                     stalled, done_cnt - d0, exp_tx.size());
        end
    endtask

    task automatic test_both_req();
        int d0;
        int rdy_seen = 0;
        int vld_seen = 0;
        tx_rdy = 1'b1;
        push_save();
        d0 = done_cnt;
        start(1'b1, 1'b1);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            tick();
            if (rx_rdy !== 1'b0) rdy_seen++;
            if (tx_vld === 1'b1) vld_seen++;
        end
        repeat (2) tick();
        checks++;
        if (rdy_seen != 0 || vld_seen != 128 || exp_tx.size() != 0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL both_req got rx_rdy_cycles=%0d tx_vld_cycles=%0d left=%0d count=%0d expected 0 128 0 1",
                     rdy_seen, vld_seen, exp_tx.size(), done_cnt - d0);
        end
    endtask

    task automatic test_rst_mid();
        int d0;
        tx_rdy = 1'b1;
        push_save();
        d0 = done_cnt;
        start(1'b1, 1'b0);
        for (int i = 0; i < 200 && sst_addr !== 8'd40; i++) tick();
        map_rst = 1'b1;
        tick();
        map_rst = 1'b0;
        checks++;
        if (sst_act !== 1'b0 || busy !== 1'b0 || sst_addr !== 8'd0 || tx_vld !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got act=%b busy=%b addr=%02h vld=%b done=%b expected all 0",
                     sst_act, busy, sst_addr, tx_vld, done);
        end
        exp_tx.delete();
        repeat (4) tick();
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL rst_mid_done got count=%0d expected=0", done_cnt - d0);
        end
        test_save();
    endtask

    task automatic test_abort();
        int d0;
        for (int i = 0; i < 128; i++) exp_wr.push_back({8'(i), 8'(i)});
        map_idx = 8'h7F;
        last_byte = 8'd127;
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
        rx_vld = 1'b1;
        d0 = done_cnt;
        start(1'b0, 1'b1);
        for (int i = 0; i < 100 && !(sst_addr === 8'd10 && rx_rdy === 1'b1); i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        rx_vld = 1'b0;
        checks++;
        if (busy !== 1'b0 || rx_rdy !== 1'b0 || sst_we_reg !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL abort_now got busy=%b rdy=%b we=%b err=%b expected 0 0 0 1", busy, rx_rdy, sst_we_reg, err);
        end
        wait_done(d0, 10);
        checks++;
        if (done_cnt - d0 != 1 || err !== 1'b1 || sst_act !== 1'b0 || exp_wr.size() != 118) begin
            failures++;
            $display("FAIL abort_end got count=%0d err=%b act=%b left=%0d expected 1 1 0 118",
                     done_cnt - d0, err, sst_act, exp_wr.size());
        end
        exp_wr.delete();
    endtask

    initial begin
        test_reset();
        test_save();
        test_load(1'b0);
        test_load(1'b1);
        test_stall();
        test_both_req();
        test_rst_mid();
        test_abort();
        test_save();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sst_engine.md
# sst_engine

Save-state initiator for the mapper save-state bus. It walks the mapper register window address by address. On save, it reads each register byte and streams it to the host. On load, it takes bytes from the host and writes them into the mapper registers. It sits between the host byte channel and every mapper's `sst` port. It is the driving end of the `sst.act / sst.addr / sst.we_reg / sst.dato / sst_di` interface.

## Interface
Parameters:
- REG_CNT, 128: number of register addresses walked, 0..REG_CNT-1.
- IDX_ADDR, 127: address holding the mapper index byte.

Ports:
- m2  in  1  system clock; all state updates on the falling edge, the same edge the mappers sample `sst`.
- map_rst  in  1  reset; synchronous, active-high.
- save_req  in  1  level; accepted only in IDLE.
- load_req  in  1  level; accepted only in IDLE.
- abort  in  1  terminates any transfer.
- map_idx  in  8  current mapper index (`cfg.map_idx`).
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse at end of a transfer, whether complete or aborted.
- err  out  1  sticky error flag; cleared when the next request is accepted.
- tx_data  out  8  saved byte to host.
- tx_vld  out  1  tx_data valid.
- tx_rdy  in  1  host accepts the byte.
- rx_data  in  8  restore byte from host.
- rx_vld  in  1  rx_data valid.
- rx_rdy  out  1  engine accepts the byte.
- sst_act  out  1  save-state active; freezes normal mapper register writes.
- sst_addr  out  8  register address.
- sst_we_reg  out  1  register write strobe.
- sst_dato  out  8  write data.
- sst_di  in  8  mapper read data, combinational from sst_addr.

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, err=0, tx_vld=0, tx_data=0, rx_rdy=0, sst_act=0, sst_addr=0, sst_we_reg=0, sst_dato=0.
- States: IDLE, SAVE_RD, SAVE_TX, LOAD_RX, LOAD_WR, DONE.
- IDLE, leaving:
  - save_req=1 → SAVE_RD with sst_addr=0, sst_act=1, err=0.
  - else load_req=1 → LOAD_RX, same outputs.
  - Both requests high: save wins.
- SAVE_RD: capture tx_data←sst_di, set tx_vld=1 → SAVE_TX.
- SAVE_TX: on tx_vld&tx_rdy, drop tx_vld, then:
  - sst_addr==REG_CNT-1 → DONE.
  - otherwise sst_addr+1 → SAVE_RD.
  - tx_data and tx_vld stay stable while tx_rdy=0.
- LOAD_RX:
  - rx_rdy=1 while in this state.
  - On rx_vld&rx_rdy: sst_dato←rx_data, rx_rdy=0 → LOAD_WR.
- LOAD_WR: sst_we_reg=1 for exactly this one cycle, then:
  - last address → DONE.
  - otherwise sst_addr+1 → LOAD_RX.
- DONE, one cycle:
  - done=1, sst_act=0, sst_addr=0 → IDLE.
  - Requests are ignored during DONE.
- sst_addr is an 8-bit counter. It never wraps inside a transfer; the terminal compare is against REG_CNT-1.
- abort=1 in any busy state:
  - next state DONE with err=1.
  - tx_vld=0, rx_rdy=0, sst_we_reg=0.
  - An in-flight byte is discarded.
- map_rst takes priority over everything, including abort and requests. It resets the engine to IDLE with all reset values on the next edge, even mid-transfer.

## Timing
- Request accepted at edge N: sst_act=1 and sst_addr=0 valid after edge N.
- Save, with tx_rdy held high: 2 cycles per byte.
  - First tx_vld after edge N+1.
  - done after edge N+2·REG_CNT+1.
- Load, with rx_vld held high: 2 cycles per byte (LOAD_RX, LOAD_WR).
  - sst_we_reg pulses every second cycle.
  - sst_addr and sst_dato are stable during every pulse.
- sst_act falls on the same edge done rises.
- The final write strobe occurs while sst_act is still high.

## Configuration
- Macro: SST_IDX_CHECK_EN.
- Defined: in LOAD_RX at sst_addr==IDX_ADDR, the accepted rx_data is compared with map_idx.
  - Mismatch: no write strobe is issued; err=1 → DONE.
  - Match: normal write.
- Undefined: the byte at IDX_ADDR is written like any other byte, and err is set only by abort.

## Test plan
- Save, tx_rdy=1, mapper model sst_di=addr^8'h5A, map_idx=8'h53 at addr 127 → 128 bytes 8'h5A, 8'h5B, …; byte 127 = 8'h53; done once, 257 cycles after request; err=0.
- Load of bytes i (i=0..127, map_idx=8'h7F), rx_vld=1 → 128 sst_we_reg pulses, each with sst_addr=i and sst_dato=i; sst_act high throughout; done once.
- Save with tx_rdy low 5 cycles at byte 3 → tx_data=8'h59 and tx_vld=1 held all 5 cycles; no duplicate or skipped byte.
- With SST_IDX_CHECK_EN, load with byte 127=8'h00 and map_idx=8'h53 → 127 strobes, none at addr 127; err=1; done. Without the macro: 128 strobes, err=0.
- map_rst during save at sst_addr=40 → next edge sst_act=0, busy=0, sst_addr=0, tx_vld=0, no done; a following save starts at addr 0.
- save_req and load_req high together in IDLE → save sequence runs (tx_vld toggles, rx_rdy stays 0).
